carbonio_irq_ctrl: RTL and testbench

//  Interrupt controller for CarbonIO. Latches the CARBONIO_IRQ_SRC_COUNT internal source pulses/levels
//  (UART RX/TX, PIO edge/match, TIMER0/1) into a pending register and applies ENABLE/MASK.

---
 rtl/carbonio_pkg.sv | 31 +++
 rtl/carbonio_irq_arb.sv | 27 ++
 rtl/carbonio_irq_ctrl.sv | 110 +++++++++++
 tb/tb_carbonio_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/carbonio_pkg.sv
// Shared CarbonIO interrupt definitions: source indices, IRQ FSM states and
// register-select encodings. Used by carbonio_irq_ctrl and carbonio_irq_arb.
package carbonio_pkg;

    localparam int CARBONIO_IRQ_SRC_UART_RX   = 0;
    localparam int CARBONIO_IRQ_SRC_UART_TX   = 1;
    localparam int CARBONIO_IRQ_SRC_PIO_EDGE  = 2;
    localparam int CARBONIO_IRQ_SRC_PIO_MATCH = 3;
    localparam int CARBONIO_IRQ_SRC_TIMER0    = 4;
    localparam int CARBONIO_IRQ_SRC_TIMER1    = 5;
    localparam int CARBONIO_IRQ_SRC_COUNT     = 6;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] IRQ_SEL_ENABLE  = 2'd0;
    localparam logic [1:0] IRQ_SEL_PENDING = 2'd1;
    localparam logic [1:0] IRQ_SEL_MASK    = 2'd2;
    localparam logic [1:0] IRQ_SEL_RSVD    = 2'd3;

    // (base + off) mod n, for base < n and off < n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/carbonio_irq_arb.sv
// Combinational interrupt arbiter: picks the first eligible source searching
// upward from ptr with wrap. ptr tied to 0 gives fixed lowest-index priority.
module carbonio_irq_arb
    import carbonio_pkg::*;
#(
    parameter int N_SRC = CARBONIO_IRQ_SRC_COUNT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible[wrap_idx(int'(ptr), k, N_SRC)]) begin
                valid = 1'b1;
                id    = ID_W'(wrap_idx(int'(ptr), k, N_SRC));
            end
        end
    end

endmodule

// File: rtl/carbonio_irq_ctrl.sv
// CarbonIO interrupt controller: edge-latched pending register, ENABLE/MASK,
// ack/EOI handshake FSM. Define CARBONIO_IRQ_RR_EN for round-robin arbitration.
module carbonio_irq_ctrl
    import carbonio_pkg::*;
#(
    parameter int N_SRC = CARBONIO_IRQ_SRC_COUNT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_i,
    input  logic             reg_we,
    input  logic [1:0]       reg_sel,
    input  logic [N_SRC-1:0] reg_wdata,
    output logic [N_SRC-1:0] reg_rdata,
    output logic             irq_o,
    output logic [ID_W-1:0]  irq_id_o,
    input  logic             irq_ack_i,
    input  logic             irq_eoi_i,
    output logic             in_service_o
);

    logic [N_SRC-1:0] enable_q, mask_q, pending_q, src_prev_q;
    logic [N_SRC-1:0] src_edge, eligible, pend_clr, pending_d;
    logic [ID_W-1:0]  irq_id_d, arb_id, ptr;
    logic             arb_valid, ack_take, irq_d, svc_d;
    irq_state_e       state_q, state_d;

    assign src_edge = src_i & ~src_prev_q;
    assign eligible = pending_q & enable_q & ~mask_q;
    assign ack_take = (state_q == IRQ_ASSERT) && irq_ack_i;

    // Clears are applied before OR-ing in new edges so a same-cycle set wins.
    always_comb begin
        pend_clr = '0;
        if (reg_we && reg_sel == IRQ_SEL_PENDING) pend_clr = reg_wdata;
        if (ack_take) pend_clr[irq_id_o] = 1'b1;
        pending_d = (pending_q & ~pend_clr) | src_edge;
    end

    carbonio_irq_arb #(.N_SRC(N_SRC), .ID_W(ID_W)) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .valid    (arb_valid),
        .id       (arb_id)
    );

`ifdef CARBONIO_IRQ_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ptr <= '0;
        else if (ack_take) ptr <= (irq_id_o == ID_W'(N_SRC - 1)) ? '0 : irq_id_o + ID_W'(1);
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_o;
        case (state_q)
            IRQ_IDLE: begin
                if (arb_valid) begin
                    state_d  = IRQ_ASSERT;
                    irq_id_d = arb_id;
                end
            end
            IRQ_ASSERT: begin
                // Ack beats a simultaneous withdrawal.
                if (irq_ack_i)               state_d = IRQ_SERVICE;
                else if (!eligible[irq_id_o]) state_d = IRQ_IDLE;
            end
            IRQ_SERVICE: if (irq_eoi_i) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
        irq_d = (state_d == IRQ_ASSERT);
        svc_d = (state_d == IRQ_SERVICE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            src_prev_q   <= '0;
            state_q      <= IRQ_IDLE;
            irq_o        <= 1'b0;
            irq_id_o     <= '0;
            in_service_o <= 1'b0;
        end else begin
            src_prev_q   <= src_i;
            pending_q    <= pending_d;
            state_q      <= state_d;
            irq_o        <= irq_d;
            irq_id_o     <= irq_id_d;
            in_service_o <= svc_d;
            if (reg_we && reg_sel == IRQ_SEL_ENABLE) enable_q <= reg_wdata;
            if (reg_we && reg_sel == IRQ_SEL_MASK)   mask_q   <= reg_wdata;
        end
    end

    always_comb begin
        case (reg_sel)
            IRQ_SEL_ENABLE:  reg_rdata = enable_q;
            IRQ_SEL_PENDING: reg_rdata = pending_q;
            IRQ_SEL_MASK:    reg_rdata = mask_q;
            default:         reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_carbonio_irq_ctrl.sv
// Scoreboard bench for carbonio_irq_ctrl: a rule-level model predicts outputs each
// cycle, a negedge monitor pops and compares. Honours CARBONIO_IRQ_RR_EN.
module tb_carbonio_irq_ctrl;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src, reg_wdata, reg_rdata;
    logic         reg_we, ack, eoi;
    logic [1:0]   reg_sel;
    logic         irq_o, in_service_o;
    logic [2:0]   irq_id_o;

    carbonio_irq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_i        (src),
        .reg_we       (reg_we),
        .reg_sel      (reg_sel),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (ack),
        .irq_eoi_i    (eoi),
        .in_service_o (in_service_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle, 1=presenting, 2=in service
    bit [N-1:0] m_en, m_mask, m_pend, m_prev;
    int m_ph, m_id, m_ptr;

    typedef struct { int irq; int id; int svc; int rdata; } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        m_en = '0; m_mask = '0; m_pend = '0; m_prev = '0;
        m_ph = 0; m_id = 0; m_ptr = 0;
    endtask

    function automatic int m_reg(input logic [1:0] sel);
        case (sel)
            2'd0:    return int'(m_en);
            2'd1:    return int'(m_pend);
            2'd2:    return int'(m_mask);
            default: return 0;
        endcase
    endfunction

    function automatic int m_pick(input bit [N-1:0] elig);
        for (int k = 0; k < N; k++)
            if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit [N-1:0] edges, elig, np;
        int w;
        edges = src & ~m_prev;
        elig  = m_pend & m_en & ~m_mask;
        np    = m_pend;
        if (reg_we && reg_sel == 2'd1) np &= ~reg_wdata;
        case (m_ph)
            0: begin
                w = m_pick(elig);
                if (w >= 0) begin m_ph = 1; m_id = w; end
            end
            1: begin
                if (ack) begin
                    np[m_id] = 1'b0;
`ifdef CARBONIO_IRQ_RR_EN
                    m_ptr = (m_id + 1) % N;
`endif
                    m_ph = 2;
                end else if (!elig[m_id]) m_ph = 0;
            end
            default: if (eoi) m_ph = 0;
        endcase
        m_pend = np | edges;
        m_prev = src;
        if (reg_we && reg_sel == 2'd0) m_en   = reg_wdata;
        if (reg_we && reg_sel == 2'd2) m_mask = reg_wdata;
    endtask

    // One clock: queue the prediction for this cycle's outputs, apply the edge.
    task automatic cyc();
        exp_t e;
        e.irq = (m_ph == 1); e.id = m_id; e.svc = (m_ph == 2); e.rdata = m_reg(reg_sel);
        sb.push_back(e);
        @(posedge clk);
        model_step();
        #1;
        reg_we = 1'b0; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [N-1:0] d);
        reg_we = 1'b1; reg_sel = sel; reg_wdata = d;
        cyc();
    endtask

    task automatic peek(input logic [1:0] sel, input string name, input int exp);
        reg_sel = sel;
        #1;
        chk(name, int'(reg_rdata), exp);
    endtask

    // Serve one interrupt, bounded wait for irq_o.
    task automatic serve(output int id);
        int n = 0;
        while (!irq_o && n < 20) begin cyc(); n++; end
        chk("serve_wait_irq", int'(irq_o), 1);
        id = int'(irq_id_o);
        ack = 1'b1; cyc();
        eoi = 1'b1; cyc();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("irq_o", int'(irq_o), e.irq);
                chk("irq_id_o", int'(irq_id_o), e.id);
                chk("in_service_o", int'(in_service_o), e.svc);
                chk("reg_rdata", int'(reg_rdata), e.rdata);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int id;
        int exp_order [3];
        rst_n = 1'b0; src = '0; reg_we = 1'b0; reg_sel = 2'd0; reg_wdata = '0;
        ack = 1'b0; eoi = 1'b0;
        model_reset();
        #12;
        chk("rst_irq_o", int'(irq_o), 0);
        chk("rst_irq_id", int'(irq_id_o), 0);
        chk("rst_in_service", int'(in_service_o), 0);
        peek(2'd0, "rst_enable", 0);
        peek(2'd1, "rst_pending", 0);
        peek(2'd2, "rst_mask", 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single source, full handshake
        wr(2'd0, 6'h3F);
        src = 6'h10; reg_sel = 2'd1; cyc();
        chk("t1_pending", int'(reg_rdata), 'h10);
        chk("t1_irq_not_yet", int'(irq_o), 0);
        src = 6'h00; cyc();
        chk("t1_irq", int'(irq_o), 1);
        chk("t1_id", int'(irq_id_o), 4);
        ack = 1'b1; cyc();
        chk("t1_svc", int'(in_service_o), 1);
        chk("t1_pending_cleared", int'(reg_rdata), 0);
        eoi = 1'b1; cyc();
        chk("t1_eoi_idle", int'(in_service_o), 0);

        // Three simultaneous sources
        src = 6'h2A; cyc();
        src = 6'h00;
`ifdef CARBONIO_IRQ_RR_EN
        exp_order = '{5, 1, 3};  // pointer is 5 after the id-4 ack above
`else
        exp_order = '{1, 3, 5};
`endif
        for (int i = 0; i < 3; i++) begin
            serve(id);
            chk("t2_order", id, exp_order[i]);
        end

        // Withdrawal on mask, re-assert on unmask
        src = 6'h04; cyc();
        src = 6'h00; cyc();
        chk("t3_irq", int'(irq_o), 1);
        chk("t3_id", int'(irq_id_o), 2);
        wr(2'd2, 6'h04);
        reg_sel = 2'd1; cyc();
        chk("t3_withdrawn", int'(irq_o), 0);
        chk("t3_still_pending", int'(reg_rdata), 'h04);
        wr(2'd2, 6'h00);
        cyc();
        chk("t3_reassert", int'(irq_o), 1);
        chk("t3_reassert_id", int'(irq_id_o), 2);
        ack = 1'b1; cyc();
        eoi = 1'b1; cyc();

        // Set/clear conflicts
        src = 6'h01; reg_we = 1'b1; reg_sel = 2'd1; reg_wdata = 6'h01; cyc();
        chk("t4_set_wins_w1c", int'(reg_rdata), 'h01);
        src = 6'h00; cyc();
        chk("t4_irq0", int'(irq_o), 1);
        src = 6'h01; ack = 1'b1; cyc();
        chk("t4_set_wins_ack", int'(reg_rdata), 'h01);
        src = 6'h00; eoi = 1'b1; cyc();
        serve(id);
        chk("t4_reserved_id", id, 0);

        // Ignored ack/eoi, then async reset in service
        wr(2'd0, 6'h00);
        wr(2'd1, 6'h3F);
        ack = 1'b1; cyc();
        chk("t5_ack_idle_svc", int'(in_service_o), 0);
        wr(2'd0, 6'h3F);
        src = 6'h08; cyc();
        src = 6'h00; cyc();
        eoi = 1'b1; cyc();
        chk("t5_eoi_in_assert", int'(irq_o), 1);
        ack = 1'b1; cyc();
        chk("t5_in_service", int'(in_service_o), 1);
        src = 6'h01; rst_n = 1'b0;
        #1;
        chk("t5_rst_irq_o", int'(irq_o), 0);
        chk("t5_rst_svc", int'(in_service_o), 0);
        chk("t5_rst_id", int'(irq_id_o), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Source high through reset release is an edge
        wr(2'd0, 6'h01);
        reg_sel = 2'd1; cyc();
        chk("t6_irq", int'(irq_o), 1);
        chk("t6_pending", int'(reg_rdata), 'h01);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            src     = N'($urandom_range(0, 63));
            reg_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                reg_we    = 1'b1;
                reg_wdata = N'($urandom_range(0, 63));
            end
            ack = ($urandom_range(0, 2) == 0);
            eoi = ($urandom_range(0, 3) == 0);
            cyc();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
